// File: rtl/secure_tx_pkg.sv
// Shared types and constants for the masked credential transmitter.
package secure_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } tx_state_e;

  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h80200003;

endpackage

// File: rtl/cred_keystream_lfsr.sv
// Galois LFSR keystream generator; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module cred_keystream_lfsr #(
  parameter int          W    = 32,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         step,
  input  logic         clear,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] state_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= '0;
    end else if (clear) begin
      state_reg <= '0;
    end else if (load) begin
      state_reg <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      state_reg <= (state_reg >> 1) ^ (state_reg[0] ? TAPS : '0);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/secure_cred_tx.sv
// Serialises a credential into BEAT_W beats, LSB first, each XOR-masked with
// a per-beat LFSR keystream; zeroize aborts and wipes all working state.
module secure_cred_tx
  import secure_tx_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                BEAT_W    = 32,
  parameter logic [BEAT_W-1:0] LFSR_TAPS = BEAT_W'(DEFAULT_LFSR_TAPS),
  parameter bit                MASK_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] cred_in,
  input  logic              cred_valid,
  output logic              cred_ready,
  input  logic [BEAT_W-1:0] key_seed,
  output logic [BEAT_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  input  logic              zeroize,
  output logic              abort,
  output logic              busy
);

  localparam int NBEATS = DATA_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (DATA_W % BEAT_W != 0) begin : g_width_check
    $error("secure_cred_tx: DATA_W must be a multiple of BEAT_W");
  end

  tx_state_e         state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic              tx_valid_reg;
  logic              abort_reg;
  logic              busy_reg;
  logic [BEAT_W-1:0] lfsr_state;
  logic [BEAT_W-1:0] keystream;

  logic accept;
  logic beat_hs;
  logic last_beat;

  assign cred_ready = (state_reg == IDLE) && !zeroize;
  assign accept     = cred_valid && cred_ready;
  assign beat_hs    = tx_valid_reg && tx_ready;
  assign last_beat  = (beat_cnt_reg == CNT_W'(NBEATS - 1));

  cred_keystream_lfsr #(
    .W    (BEAT_W),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .step    ((state_reg == SEND) && beat_hs && !zeroize),
    .clear   (state_reg == CLEAR),
    .seed    (key_seed),
    .state   (lfsr_state)
  );

  if (MASK_EN) begin : g_mask
    assign keystream = lfsr_state;
  end else begin : g_nomask
    assign keystream = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      beat_cnt_reg <= '0;
      tx_valid_reg <= 1'b0;
      abort_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (zeroize) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
          end else if (accept) begin
            state_reg    <= SEND;
            shreg_reg    <= cred_in;
            beat_cnt_reg <= '0;
            tx_valid_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        SEND: begin
          // zeroize wins over a same-cycle handshake: the beat is not consumed
          if (zeroize) begin
            state_reg    <= CLEAR;
            tx_valid_reg <= 1'b0;
            abort_reg    <= 1'b1;
          end else if (beat_hs) begin
            shreg_reg    <= shreg_reg >> BEAT_W;
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (last_beat) begin
              state_reg    <= CLEAR;
              tx_valid_reg <= 1'b0;
            end
          end
        end
        CLEAR: begin
          shreg_reg    <= '0;
          beat_cnt_reg <= '0;
          if (!zeroize) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg    <= CLEAR;
          tx_valid_reg <= 1'b0;
          busy_reg     <= 1'b1;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_reg;
  assign tx_last  = tx_valid_reg && last_beat;
  assign tx_data  = tx_valid_reg ? (shreg_reg[BEAT_W-1:0] ^ keystream) : '0;
  assign abort    = abort_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_secure_cred_tx.sv
// Randomised bench for secure_cred_tx against a keystream/slice reference model.
module tb_secure_cred_tx;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] cred_in;
  logic         cred_valid;
  logic         cred_ready;
  logic [31:0]  key_seed;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;
  logic         zeroize;
  logic         abort;
  logic         busy;

  logic [63:0]  b_cred_in;
  logic         b_cred_valid;
  logic         b_cred_ready;
  logic [15:0]  b_key_seed;
  logic [15:0]  b_tx_data;
  logic         b_tx_valid;
  logic         b_tx_ready;
  logic         b_tx_last;
  logic         b_zeroize;
  logic         b_abort;
  logic         b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  secure_cred_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cred_in    (cred_in),
    .cred_valid (cred_valid),
    .cred_ready (cred_ready),
    .key_seed   (key_seed),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .zeroize    (zeroize),
    .abort      (abort),
    .busy       (busy)
  );

  secure_cred_tx #(
    .DATA_W  (64),
    .BEAT_W  (16),
    .MASK_EN (1'b0)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .cred_in    (b_cred_in),
    .cred_valid (b_cred_valid),
    .cred_ready (b_cred_ready),
    .key_seed   (b_key_seed),
    .tx_data    (b_tx_data),
    .tx_valid   (b_tx_valid),
    .tx_ready   (b_tx_ready),
    .tx_last    (b_tx_last),
    .zeroize    (b_zeroize),
    .abort      (b_abort),
    .busy       (b_busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keystream word for beat idx: seed (0 -> 1) advanced idx Galois steps.
  function automatic logic [31:0] key_at(input logic [31:0] seed, input int idx);
    logic [31:0] k;
    k = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < idx; i++)
      k = (k / 2) ^ ((k % 2 == 1) ? TAPS : 32'd0);
    return k;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [127:0] cred, input logic [31:0] seed,
                                           input int idx);
    return cred[32*idx +: 32] ^ key_at(seed, idx);
  endfunction

  // mode: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready.
  task automatic send(input logic [127:0] cred, input logic [31:0] seed, input int mode,
                      input int zero_beat, input int rst_beat);
    int beat;
    int cyc;
    bit done;
    beat = 0;
    cyc  = 0;
    done = 1'b0;
    @(negedge clk);
    cred_in    = cred;
    key_seed   = seed;
    cred_valid = 1'b1;
    tx_ready   = 1'b0;
    #1;
    chk("cred_ready_idle", cred_ready, 1);
    chk("busy_idle", busy, 0);
    chk("tx_data_idle", tx_data, 0);
    @(negedge clk);
    cred_valid = 1'b0;
    cred_in    = {$urandom, $urandom, $urandom, $urandom};
    key_seed   = $urandom;
    while (!done && cyc < 200) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: tx_ready = $urandom_range(0, 1) == 1;
      endcase
      if (beat == zero_beat) begin
        zeroize  = 1'b1;
        tx_ready = 1'b1;
      end
      #1;
      chk("tx_valid", tx_valid, 1);
      chk("tx_data", tx_data, exp_beat(cred, seed, beat));
      chk("tx_last", tx_last, (beat == 3));
      chk("busy_send", busy, 1);
      chk("cred_ready_send", cred_ready, 0);
      if (beat == rst_beat) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_abort", abort, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_cred_ready", cred_ready, 1);
        chk("rst_abort_after", abort, 0);
        return;
      end
      if (zeroize) begin
        @(negedge clk);
        zeroize  = 1'b0;
        tx_ready = 1'b0;
        #1;
        chk("zero_tx_valid", tx_valid, 0);
        chk("zero_tx_data", tx_data, 0);
        chk("zero_abort", abort, 1);
        chk("zero_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("zero_abort_end", abort, 0);
        chk("zero_busy_end", busy, 0);
        chk("zero_cred_ready", cred_ready, 1);
        chk("zero_shreg", dut.shreg_reg, 0);
        chk("zero_lfsr", dut.lfsr_state, 0);
        chk("zero_beat_cnt", dut.beat_cnt_reg, 0);
        return;
      end
      if (tx_ready) beat++;
      if (beat == 4) done = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk("completed", done, 1);
    tx_ready = 1'b0;
    #1;
    chk("clear_tx_valid", tx_valid, 0);
    chk("clear_tx_data", tx_data, 0);
    chk("clear_busy", busy, 1);
    chk("clear_cred_ready", cred_ready, 0);
    chk("clear_abort", abort, 0);
    @(negedge clk);
    #1;
    chk("done_busy", busy, 0);
    chk("done_cred_ready", cred_ready, 1);
    $display("xfer cred=%h seed=%h mode=%0d beats=%0d", cred, seed, mode, beat);
  endtask

  task automatic send_b(input logic [63:0] cred);
    int beat;
    int cyc;
    beat = 0;
    cyc  = 0;
    @(negedge clk);
    b_cred_in    = cred;
    b_key_seed   = 16'($urandom);
    b_cred_valid = 1'b1;
    b_tx_ready   = 1'b0;
    #1;
    chk("b_cred_ready", b_cred_ready, 1);
    @(negedge clk);
    b_cred_valid = 1'b0;
    while (beat < 4 && cyc < 100) begin
      b_tx_ready = $urandom_range(0, 1) == 1;
      #1;
      chk("b_tx_valid", b_tx_valid, 1);
      chk("b_tx_data", b_tx_data, cred[16*beat +: 16]);
      chk("b_tx_last", b_tx_last, (beat == 3));
      if (b_tx_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    chk("b_completed", beat, 4);
    b_tx_ready = 1'b0;
    #1;
    chk("b_clear_tx_valid", b_tx_valid, 0);
    @(negedge clk);
    #1;
    chk("b_done_busy", b_busy, 0);
    $display("xfer_b cred=%h beats=%0d", cred, beat);
  endtask

  initial begin
    logic [127:0] directed;
    directed     = 128'h0123456789abcdeffedcba9876543210;
    reset_n      = 1'b0;
    cred_in      = '0;
    cred_valid   = 1'b0;
    key_seed     = '0;
    tx_ready     = 1'b0;
    zeroize      = 1'b0;
    b_cred_in    = '0;
    b_cred_valid = 1'b0;
    b_key_seed   = '0;
    b_tx_ready   = 1'b0;
    b_zeroize    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_tx_last", tx_last, 0);
    chk("reset_abort", abort, 0);
    chk("reset_busy", busy, 0);
    chk("reset_shreg", dut.shreg_reg, 0);
    chk("reset_lfsr", dut.lfsr_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_cred_ready", cred_ready, 1);

    send(directed, 32'd0, 0, -1, -1);
    send(directed, 32'd0, 1, -1, -1);
    send(directed, 32'd0, 0, 1, -1);
    send({$urandom, $urandom, $urandom, $urandom}, $urandom, 0, -1, 2);
    send({$urandom, $urandom, $urandom, $urandom}, $urandom, 2, -1, -1);

    // zeroize while idle: CLEAR, held while zeroize stays high, never aborts
    @(negedge clk);
    zeroize    = 1'b1;
    cred_valid = 1'b1;
    #1;
    chk("zidle_cred_ready", cred_ready, 0);
    @(negedge clk);
    #1;
    chk("zidle_busy", busy, 1);
    chk("zidle_abort", abort, 0);
    chk("zidle_tx_valid", tx_valid, 0);
    @(negedge clk);
    zeroize    = 1'b0;
    cred_valid = 1'b0;
    #1;
    chk("zidle_hold_busy", busy, 1);
    chk("zidle_hold_abort", abort, 0);
    @(negedge clk);
    #1;
    chk("zidle_busy_end", busy, 0);
    chk("zidle_cred_ready_end", cred_ready, 1);

    for (int i = 0; i < 6; i++)
      send({$urandom, $urandom, $urandom, $urandom}, (i == 0) ? 32'd0 : $urandom,
           2, (i == 3) ? int'($urandom_range(0, 3)) : -1, -1);

    for (int i = 0; i < 3; i++)
      send_b({$urandom, $urandom});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/secure_cred_tx.md
SECURE_CRED_TX -- requirements
Module: secure_cred_tx

Interface
REQ-001 Parameter DATA_W, default 128: credential width in bits; SHALL be a multiple of BEAT_W.
REQ-002 Parameter BEAT_W, default 32: transmit beat width and keystream LFSR width.
REQ-003 Parameter LFSR_TAPS, default 32'h80200003: Galois feedback mask, BEAT_W bits wide.
REQ-004 Parameter MASK_EN, default 1: 1 = masked transmit; 0 = keystream forced to 0 (debug builds only).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low; ports SHALL be clk and reset_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 cred_in  in  DATA_W  credential to transmit.
REQ-009 cred_valid  in  1  credential offered.
REQ-010 cred_ready  out  1  block can accept a credential.
REQ-011 key_seed  in  BEAT_W  keystream seed, sampled with cred_in.
REQ-012 tx_data  out  BEAT_W  masked beat.
REQ-013 tx_valid  out  1  tx_data valid.
REQ-014 tx_ready  in  1  sink accepts beat.
REQ-015 tx_last  out  1  final beat of credential.
REQ-016 zeroize  in  1  abort and wipe request.
REQ-017 abort  out  1  one-cycle pulse when an in-flight transfer is zeroized.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, SEND, CLEAR.
REQ-020 cred_ready SHALL be 1 only in IDLE with zeroize low.
REQ-021 Accept (cred_valid & cred_ready): shreg <= cred_in; lfsr <= (key_seed == 0) ? 1 : key_seed; beat_cnt <= 0; state -> SEND.
REQ-022 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal shreg[BEAT_W-1:0] ^ (MASK_EN ? lfsr : 0); beats go LSB first.
REQ-023 On a beat handshake (tx_valid & tx_ready): shreg shifts right BEAT_W with zero fill; lfsr steps as (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 0); beat_cnt increments.
REQ-024 tx_last SHALL be 1 exactly when beat_cnt == DATA_W/BEAT_W - 1 in SEND.
REQ-025 With tx_valid high and tx_ready low, tx_data, tx_last and all state SHALL hold unchanged (no drop, no duplicate).
REQ-026 A handshake on the last beat SHALL move the FSM to CLEAR; CLEAR SHALL zero shreg, lfsr and beat_cnt, then return to IDLE after one cycle.
REQ-027 tx_data SHALL be 0 whenever tx_valid is 0; the unmasked credential SHALL never appear on any output.
REQ-028 zeroize in SEND SHALL take priority over a simultaneous handshake: go to CLEAR, pulse abort, and drop tx_valid the next cycle.
REQ-029 zeroize in IDLE or CLEAR SHALL go to CLEAR (stay in CLEAR) with no abort pulse and no accept.
REQ-030 Back-to-back operation: the earliest next accept SHALL be the cycle after CLEAR (gap of one cycle).

Reset
REQ-031 Reset SHALL force IDLE; shreg, lfsr, beat_cnt, tx_data, tx_valid, tx_last, abort and busy SHALL all be 0; cred_ready SHALL be 1 after release.
REQ-032 Reset asserted mid-transfer SHALL drop tx_valid immediately and emit no abort pulse.

Structure
REQ-033 Package secure_tx_pkg SHALL hold the state enum and the default LFSR_TAPS constant.
REQ-034 Sub-module cred_keystream_lfsr (load, step, seed, state out; seed-zero substitution inside) SHALL implement the keystream.
REQ-035 Elaboration SHALL fail when DATA_W % BEAT_W != 0.

Verification
REQ-036 Defaults, key_seed=0, cred_in=128'h0123..., tx_ready=1 -> beat0 = cred[31:0]^32'h00000001, beat1 = cred[63:32]^32'h80200003, 4 beats, tx_last on beat3, busy low 2 cycles after the last beat.
REQ-037 Same stimulus with tx_ready toggling 1-0-0-1 -> tx_data and tx_last held during stall, beat sequence identical to REQ-036.
REQ-038 zeroize asserted together with the beat1 handshake -> beat1 not consumed, abort pulse of 1 cycle, tx_valid 0 next cycle, internal registers 0 at return to IDLE.
REQ-039 MASK_EN=0, DATA_W=64, BEAT_W=16 -> 4 beats equal to the raw credential slices, LSB first.
REQ-040 reset_n low in SEND at beat 2 -> all outputs 0 asynchronously; after release, cred_ready=1 and a new transfer completes correctly.
